// File: rtl/clock_domain_gen.sv
// Clock/reset sequencer: registered divided core clocks, staged core reset release and halt handshake.
// Define CLKGEN_CYCLE_COUNT_EN to build the proc_cycles processor-cycle counter.
module clock_domain_gen #(
    parameter int DIV_PROC           = 4,
    parameter int RST_HOLD_CYCLES    = 4,
    parameter int WARMUP_PROC_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    output logic        imem_clock,
    output logic        dmem_clock,
    output logic        regfile_clock,
    output logic        processor_clock,
    output logic        proc_reset,
    output logic        ready,
    output logic        halted,
    output logic [31:0] proc_cycles
);
    localparam int CNT_W  = (DIV_PROC > 2) ? $clog2(DIV_PROC) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int WARM_W = $clog2(WARMUP_PROC_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV_PROC - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(DIV_PROC / 2);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARMUP_PROC_CYCLES);

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_WARM  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [WARM_W-1:0] r_warmCnt;
    logic              r_procClock;
    logic              r_regfileClock;
    logic              r_imemClock;
    logic              r_dmemClock;
    logic              r_procReset;
    logic              r_ready;
    logic              r_halted;

    logic              w_wrap;
    logic [CNT_W-1:0]  w_cntNext;
    logic              w_procNext;

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign w_cntNext  = w_wrap ? '0 : (r_cnt + CNT_ONE);
    assign w_procNext = (w_cntNext < CNT_HALF);

    // Free-running divider in WARM/RUN; state-specific branches below override it (last NBA wins).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_RESET;
            r_cnt          <= '0;
            r_holdCnt      <= '0;
            r_warmCnt      <= '0;
            r_procClock    <= 1'b0;
            r_regfileClock <= 1'b0;
            r_imemClock    <= 1'b0;
            r_dmemClock    <= 1'b0;
            r_procReset    <= 1'b1;
            r_ready        <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            if ((r_state == S_WARM) || (r_state == S_RUN)) begin
                r_cnt          <= w_cntNext;
                r_procClock    <= w_procNext;
                r_regfileClock <= ~w_procNext;
                r_imemClock    <= ~r_imemClock;
                r_dmemClock    <= r_imemClock;
            end
            case (r_state)
                S_RESET: begin
                    r_state   <= S_HOLD;
                    r_holdCnt <= HOLD_ONE;
                end
                S_HOLD: begin
                    if (r_holdCnt == HOLD_LAST) begin
                        r_state        <= S_WARM;
                        r_cnt          <= '0;
                        r_warmCnt      <= WARM_ONE;
                        r_procClock    <= 1'b1;
                        r_regfileClock <= 1'b0;
                        r_imemClock    <= 1'b1;
                        r_dmemClock    <= 1'b0;
                    end else begin
                        r_holdCnt <= r_holdCnt + HOLD_ONE;
                    end
                end
                // Release lands on a processor_clock falling edge once enough rises were seen.
                S_WARM: begin
                    if (w_wrap && (r_warmCnt != WARM_DONE)) begin
                        r_warmCnt <= r_warmCnt + WARM_ONE;
                    end
                    if ((w_cntNext == CNT_HALF) && (r_warmCnt == WARM_DONE)) begin
                        r_state     <= S_RUN;
                        r_procReset <= 1'b0;
                        r_ready     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_wrap && halt) begin
                        r_state        <= S_HALT;
                        r_cnt          <= '0;
                        r_procClock    <= 1'b0;
                        r_regfileClock <= 1'b0;
                        r_imemClock    <= 1'b0;
                        r_dmemClock    <= 1'b0;
                        r_halted       <= 1'b1;
                        r_ready        <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (!halt) begin
                        r_state        <= S_RUN;
                        r_cnt          <= '0;
                        r_procClock    <= 1'b1;
                        r_regfileClock <= 1'b0;
                        r_imemClock    <= 1'b1;
                        r_dmemClock    <= 1'b0;
                        r_halted       <= 1'b0;
                        r_ready        <= 1'b1;
                    end
                end
                default: r_state <= S_RESET;
            endcase
        end
    end

    assign imem_clock      = r_imemClock;
    assign dmem_clock      = r_dmemClock;
    assign regfile_clock   = r_regfileClock;
    assign processor_clock = r_procClock;
    assign proc_reset      = r_procReset;
    assign ready           = r_ready;
    assign halted          = r_halted;

`ifdef CLKGEN_CYCLE_COUNT_EN
    logic [31:0] r_procCycles;
    logic        w_cycleInc;

    // Counts processor_clock rises in RUN, including the resume edge out of HALT.
    assign w_cycleInc = ((r_state == S_RUN) && w_wrap && !halt) ||
                        ((r_state == S_HALT) && !halt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_procCycles <= '0;
        end else if (w_cycleInc) begin
            r_procCycles <= r_procCycles + 32'd1;
        end
    end

    assign proc_cycles = r_procCycles;
`else
    assign proc_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_clock_domain_gen.sv
// Directed bench for clock_domain_gen: startup vector table, steady RUN, halt handshake, async reset.
`timescale 1ns/1ps
module tb_clock_domain_gen;
    logic        clock;
    logic        reset;
    logic        halt;
    logic        imem_clock;
    logic        dmem_clock;
    logic        regfile_clock;
    logic        processor_clock;
    logic        proc_reset;
    logic        ready;
    logic        halted;
    logic [31:0] proc_cycles;

    clock_domain_gen #(
        .DIV_PROC(4),
        .RST_HOLD_CYCLES(4),
        .WARMUP_PROC_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .halt(halt),
        .imem_clock(imem_clock),
        .dmem_clock(dmem_clock),
        .regfile_clock(regfile_clock),
        .processor_clock(processor_clock),
        .proc_reset(proc_reset),
        .ready(ready),
        .halted(halted),
        .proc_cycles(proc_cycles)
    );

`ifdef CLKGEN_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Vector bits: {processor, regfile, imem, dmem, proc_reset, ready, halted}
    typedef struct {
        logic        rst;
        logic        hlt;
        logic [6:0]  expVec;
        logic [31:0] expCyc;
        string       name;
    } vec_t;

    vec_t        vecs [18];
    int          nChecks = 0;
    int          nFails  = 0;
    int          ph;
    logic [31:0] cycExp;

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic setVec(input int idx, input logic rst, input logic [6:0] v,
                          input logic [31:0] c, input string name);
        vecs[idx].rst    = rst;
        vecs[idx].hlt    = 1'b0;
        vecs[idx].expVec = v;
        vecs[idx].expCyc = c;
        vecs[idx].name   = name;
    endtask

    task automatic applyStimulus(input logic rst, input logic hlt);
        @(negedge clock);
        reset = rst;
        halt  = hlt;
        @(posedge clock);
        #5;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] expVec, input logic [31:0] expCyc);
        logic [6:0]  got;
        logic [31:0] want;
        got  = {processor_clock, regfile_clock, imem_clock, dmem_clock, proc_reset, ready, halted};
        want = CNT_EN ? expCyc : 32'd0;
        nChecks++;
        if (got !== expVec) begin
            nFails++;
            $display("[TB] FAIL %s outputs: got %b expected %b", name, got, expVec);
        end
        nChecks++;
        if (proc_cycles !== want) begin
            nFails++;
            $display("[TB] FAIL %s proc_cycles: got %0d expected %0d", name, proc_cycles, want);
        end
    endtask

    task automatic runTable(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            applyStimulus(vecs[k].rst, vecs[k].hlt);
            checkOutput(vecs[k].name, vecs[k].expVec, vecs[k].expCyc);
        end
    endtask

    // One RUN master cycle against the 4-phase processor-clock model.
    task automatic runStep(input logic hlt, input string name);
        logic p;
        logic i;
        ph = (ph + 1) % 4;
        if (ph == 0) cycExp = cycExp + 32'd1;
        p = (ph < 2);
        i = (ph % 2 == 0);
        applyStimulus(1'b1, hlt);
        checkOutput(name, {p, ~p, i, ~i, 3'b010}, cycExp);
    endtask

    task automatic enterHalt(input string name);
        while (ph != 3) runStep(1'b1, "haltLead");
        applyStimulus(1'b1, 1'b1);
        checkOutput(name, 7'b0000001, cycExp);
    endtask

    task automatic resumeRun(input string name);
        applyStimulus(1'b1, 1'b0);
        ph     = 0;
        cycExp = cycExp + 32'd1;
        checkOutput(name, 7'b1010010, cycExp);
    endtask

    task automatic asyncReset(input string name);
        #2 reset = 1'b0;
        #1;
        cycExp = 32'd0;
        checkOutput(name, 7'b0000100, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        halt  = 1'b0;
        ph    = 0;
        cycExp = 32'd0;

        setVec(0,  1'b0, 7'b0000100, 32'd0, "rstLow0");
        setVec(1,  1'b0, 7'b0000100, 32'd0, "rstLow1");
        setVec(2,  1'b1, 7'b0000100, 32'd0, "hold_e1");
        setVec(3,  1'b1, 7'b0000100, 32'd0, "hold_e2");
        setVec(4,  1'b1, 7'b0000100, 32'd0, "hold_e3");
        setVec(5,  1'b1, 7'b0000100, 32'd0, "hold_e4");
        setVec(6,  1'b1, 7'b1010100, 32'd0, "warm_e5");
        setVec(7,  1'b1, 7'b1001100, 32'd0, "warm_e6");
        setVec(8,  1'b1, 7'b0110100, 32'd0, "warm_e7");
        setVec(9,  1'b1, 7'b0101100, 32'd0, "warm_e8");
        setVec(10, 1'b1, 7'b1010100, 32'd0, "warm_e9");
        setVec(11, 1'b1, 7'b1001100, 32'd0, "warm_e10");
        setVec(12, 1'b1, 7'b0110010, 32'd0, "run_e11");
        setVec(13, 1'b1, 7'b0101010, 32'd0, "run_e12");
        setVec(14, 1'b1, 7'b1010010, 32'd1, "run_e13");
        setVec(15, 1'b1, 7'b1001010, 32'd1, "run_e14");
        setVec(16, 1'b1, 7'b0110010, 32'd1, "run_e15");
        setVec(17, 1'b1, 7'b0101010, 32'd1, "run_e16");

        runTable(0, 17);
        ph = 3;
        cycExp = 32'd1;

        for (int n = 0; n < 100; n++) runStep(1'b0, "steady");

        // halt raised mid processor cycle, held, then dropped
        runStep(1'b0, "preHalt");
        for (int n = 0; n < 3; n++) runStep(1'b1, "haltFinishCycle");
        applyStimulus(1'b1, 1'b1);
        checkOutput("haltEntry", 7'b0000001, cycExp);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("haltHold", 7'b0000001, cycExp);
        end
        resumeRun("haltResume");
        for (int n = 0; n < 3; n++) runStep(1'b0, "postResume");

        // one-cycle halt pulses away from the wrap edge are ignored
        runStep(1'b0, "prePulse");
        runStep(1'b1, "pulseAtCnt0");
        runStep(1'b0, "pulseGap");
        runStep(1'b1, "pulseAtCnt2");
        runStep(1'b0, "pulseWrap");
        for (int n = 0; n < 8; n++) runStep(1'b0, "postPulse");

        // async reset in HALT, then again in WARM
        enterHalt("haltAgain");
        asyncReset("rstInHalt");
        runTable(0, 7);
        asyncReset("rstInWarm");
        runTable(0, 17);
        ph = 3;
        cycExp = 32'd1;

        for (int n = 0; n < 36; n++) runStep(1'b0, "countRun");
        enterHalt("haltCount");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("haltCountHold", 7'b0000001, cycExp);
        end
        resumeRun("countResume");

`ifdef CLKGEN_CYCLE_COUNT_EN
        force dut.r_procCycles = 32'hFFFF_FFFF;
        cycExp = 32'hFFFF_FFFF;
        runStep(1'b0, "forced");
        release dut.r_procCycles;
        runStep(1'b0, "forcedHeld");
        runStep(1'b0, "forcedHeld");
        runStep(1'b0, "counterWrap");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/clock_domain_gen.md
Name: clock_domain_gen

Overview:
- Clock and reset sequencer between the master `clock`/`reset` pins and the processor skeleton.
- Produces `imem_clock`, `dmem_clock`, `regfile_clock` and `processor_clock` as registered, glitch-free divided clocks.
- Releases the core reset only after the memories have run a set number of warm-up cycles.
- Provides a halt handshake that freezes the core at a processor-cycle boundary.

Parameters:
- DIV_PROC, 4: master cycles per processor_clock period. Must be even and ≥2.
- RST_HOLD_CYCLES, 4: master rising edges spent in HOLD after reset release. Must be ≥1.
- WARMUP_PROC_CYCLES, 2: processor_clock rising edges with proc_reset still asserted. Must be ≥1.

Ports:
- clock, input, 1: master clock. All logic runs on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- halt, input, 1: level request to freeze the core clocks.
- imem_clock, output, 1: instruction memory clock.
- dmem_clock, output, 1: data memory clock.
- regfile_clock, output, 1: register file clock.
- processor_clock, output, 1: core pipeline clock.
- proc_reset, output, 1: active-high reset to the core.
- ready, output, 1: high in RUN.
- halted, output, 1: high in HALT.
- proc_cycles, output, 32: processor cycle count (see Optional Feature).

Behaviour:
- States: RESET, HOLD, WARM, RUN, HALT. All outputs are registered.
- reset low (async, any state):
  - state = RESET; div counter cnt = 0; all four clocks = 0.
  - proc_reset = 1, ready = 0, halted = 0, proc_cycles = 0.
- RESET→HOLD: on the first rising edge with reset high.
- HOLD:
  - Lasts exactly RST_HOLD_CYCLES rising edges, including the RESET→HOLD edge.
  - Clocks stay 0.
  - The next edge enters WARM.
- Clock generation in WARM and RUN, on each edge:
  - cnt advances 0..DIV_PROC-1 and wraps. The first WARM edge loads cnt = 0.
  - processor_clock = 1 when the updated cnt < DIV_PROC/2, else 0.
  - regfile_clock = ~processor_clock.
  - imem_clock toggles every edge. It is 1 on the first edge of WARM and on the first edge after resuming from HALT.
  - dmem_clock = ~imem_clock.
- WARM:
  - Counts processor_clock rising edges (cnt updated to 0).
  - On the edge where cnt updates to DIV_PROC/2 after WARMUP_PROC_CYCLES rises have been counted: state = RUN, proc_reset → 0, ready → 1.
  - Core reset therefore releases on a processor_clock falling edge.
- RUN:
  - halt is sampled only on the edge where cnt == DIV_PROC-1 (i.e. cnt would wrap). Pulses that do not cover that edge are ignored.
  - halt = 1 at that edge: enter HALT instead of wrapping. All clocks → 0, cnt = 0, halted → 1, ready → 0.
- HALT:
  - Clocks held at 0; proc_reset stays 0 (architectural state is preserved).
  - First edge with halt = 0: enter RUN, cnt = 0, processor_clock = 1, imem_clock = 1, halted = 0, ready = 1.
- Simultaneous events: reset low overrides everything, including halt and state transitions.

Optional Feature:
- Macro: CLKGEN_CYCLE_COUNT_EN.
- Defined: proc_cycles increments by 1 on every processor_clock rising edge in RUN, including the resume edge from HALT.
  - Not incremented in WARM or HALT.
  - Wraps modulo 2^32 (0xFFFFFFFF → 0).
  - Cleared only by reset.
- Undefined: proc_cycles is constant 0 and no counter logic is synthesized.

Test Plan (DIV_PROC=4, RST_HOLD_CYCLES=4, WARMUP_PROC_CYCLES=2, master period 20 ns):
1. Reset low for 2 edges, then high (release edge = e1):
   - All clocks 0 through e4.
   - processor_clock rises at e5 and e9, falls at e7.
   - proc_reset falls and ready rises at e11.
2. Steady RUN over 100 master cycles:
   - processor_clock period 80 ns, 50% duty.
   - regfile_clock always the exact complement of processor_clock.
   - imem_clock period 40 ns; dmem_clock always equals ~imem_clock.
3. halt raised mid-cycle and held:
   - Core finishes the current processor cycle; halted = 1 on the wrap edge; clocks 0.
   - halt dropped: RUN resumes on the next edge with processor_clock = 1 and ready = 1.
4. halt pulse of 1 master cycle that does not cover the cnt = 3 edge:
   - No HALT entry; clocks unperturbed.
5. reset low during WARM and again during HALT:
   - Immediate async return: all clocks 0, proc_reset = 1, ready = 0, halted = 0.
   - Full HOLD/WARM sequence repeats after release.
6. With CLKGEN_CYCLE_COUNT_EN defined:
   - proc_cycles = 10 after 10 RUN processor cycles, unchanged during HALT.
   - Force-load 0xFFFFFFFF, then one more cycle: proc_cycles = 0.
   - Without the macro: proc_cycles stays 0 throughout.
